dmem_lanes: RTL

- Parametrised successor to the single-cycle word data memory for the pipelined MIPS core.
- Adds byte, halfword and word access with big-endian lane selection, and sign/zero-extended loads.
- Adds a configurable registered read latency with an in-order valid pipeline, and alignment/range error reporting.
- Sits between the MEM stage and the data RAM; every accepted request, read or write, returns exactly one response.

---
 rtl/dmem_lanes.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_lanes.sv
// -----------------------------------------------------------------------------
// dmem_lanes
// Data memory for the pipelined MIPS core, placed between the MEM stage and
// the data RAM. Supports byte / halfword / word accesses with big-endian lane
// selection, sign- or zero-extended loads, a configurable registered response
// latency (READ_LAT) and error reporting for misaligned, out-of-range and
// reserved-size requests. Every accepted request produces exactly one
// response, in order.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high; clears the response pipeline
//   req_valid  request present this cycle
//   req_ready  block can accept a request (high whenever reset is low)
//   req_we     1 = store, 0 = load
//   req_size   00 byte, 01 half, 10 word, 11 reserved
//   req_signed loads only: 1 = sign-extend, 0 = zero-extend
//   req_addr   byte address
//   req_wdata  store data, right-justified
//   rsp_valid  response present this cycle
//   rsp_rdata  extended load data; 0 for stores, errors and idle cycles
//   rsp_err    request was misaligned, out of range or used reserved size
// -----------------------------------------------------------------------------
module dmem_lanes #(
   parameter int DEPTH    = 64,
   parameter int READ_LAT = 1,
   parameter int AW       = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_signed,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err
);

   localparam int          IDX_W   = $clog2(DEPTH);
   // First byte address past the end of the RAM.
   localparam logic [63:0] LIMIT   = 64'(DEPTH) * 64'd4;
   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b10;

   // Byte-lane enable mask; bit 3 is word[31:24] (big-endian offset 0).
   function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b1000 >> off;
         SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Replicate right-justified store data across every lane so that the
   // mask alone decides which bytes land in the RAM word.
   function automatic logic [31:0] lane_place(input logic [1:0]  size,
                                              input logic [31:0] wdata);
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = {4{wdata[7:0]}};
         SZ_HALF: r = {2{wdata[15:0]}};
         SZ_WORD: r = wdata;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
   function automatic logic [31:0] lane_extract(input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        sgn,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      h = off[1] ? word[15:0] : word[31:16];
      case (size)
         SZ_BYTE: r = {{24{sgn & b[7]}}, b};
         SZ_HALF: r = {{16{sgn & h[15]}}, h};
         SZ_WORD: r = word;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Alignment / size / range check. The full address is compared against
   // the RAM size so high address bits can never alias into the array.
   function automatic logic req_error(input logic [1:0]    size,
                                      input logic [AW-1:0] addr);
      logic e;
      case (size)
         SZ_BYTE: e = 1'b0;
         SZ_HALF: e = addr[0];
         SZ_WORD: e = (addr[1:0] != 2'b00);
         default: e = 1'b1;
      endcase
      return e | (64'(addr) >= LIMIT);
   endfunction

   logic [31:0]      mem_r [DEPTH];
   logic [IDX_W-1:0] word_idx_s;
   logic [1:0]       off_s;
   logic             accept_s;
   logic             err_s;
   logic             wr_en_s;
   logic [3:0]       mask_s;
   logic [31:0]      wdata_lanes_s;
   logic [31:0]      rd_word_s;
   logic [31:0]      load_s;
   logic [31:0]      s0_data_s;
   logic             s0_err_s;

   logic             valid_r [READ_LAT];
   logic [31:0]      rdata_r [READ_LAT];
   logic             err_r   [READ_LAT];

   // No backpressure: the block is ready whenever it is out of reset.
   assign req_ready     = ~reset;
   assign accept_s      = req_valid & req_ready;
   assign word_idx_s    = req_addr[IDX_W+1:2];
   assign off_s         = req_addr[1:0];
   assign err_s         = req_error(req_size, req_addr);
   assign wr_en_s       = accept_s & req_we & ~err_s;
   assign mask_s        = lane_mask(req_size, off_s);
   assign wdata_lanes_s = lane_place(req_size, req_wdata);
   // Asynchronous array read gives the word as committed by earlier edges.
   assign rd_word_s     = mem_r[word_idx_s];
   assign load_s        = lane_extract(req_size, off_s, req_signed, rd_word_s);
   assign s0_err_s      = accept_s & err_s;

   // First response stage data: only error-free loads carry data.
   always_comb begin
      s0_data_s = 32'd0;
      if (accept_s && !req_we && !err_s) begin
         s0_data_s = load_s;
      end else begin
         s0_data_s = 32'd0;
      end
   end

   // RAM byte-lane write; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int b = 0; b < 4; b++) begin
            if (mask_s[b]) begin
               mem_r[word_idx_s][8*b +: 8] <= wdata_lanes_s[8*b +: 8];
            end
         end
      end
   end

   // In-order response pipeline of READ_LAT stages; reset drops in-flight items.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < READ_LAT; i++) begin
            valid_r[i] <= 1'b0;
            rdata_r[i] <= 32'd0;
            err_r[i]   <= 1'b0;
         end
      end else begin
         valid_r[0] <= accept_s;
         rdata_r[0] <= s0_data_s;
         err_r[0]   <= s0_err_s;
         for (int i = 1; i < READ_LAT; i++) begin
            valid_r[i] <= valid_r[i-1];
            rdata_r[i] <= rdata_r[i-1];
            err_r[i]   <= err_r[i-1];
         end
      end
   end

   // Idle stages hold zero data/err, so the outputs are 0 whenever invalid.
   assign rsp_valid = valid_r[READ_LAT-1];
   assign rsp_rdata = rdata_r[READ_LAT-1];
   assign rsp_err   = err_r[READ_LAT-1];

endmodule
